uart_tx_arbiter: RTL

//  Round-robin arbiter sharing one uart_tx transmitter among N byte-stream requesters.

---
 rtl/uart_tx_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte-stream requesters, grant locked per message/burst.
// Optional: define UART_ARB_PREFIX_EN to send a channel-ID byte (PREFIX_BASE + index) at the start of each grant.

module uart_tx_arbiter #(
    parameter int         N_REQ       = 4,
    parameter int         MAX_BURST   = 16,
    parameter logic [7:0] PREFIX_BASE = 8'hF0
) (
    input  logic               s_axi_aclk,
    input  logic               s_axi_aresetn,
    input  logic               clear,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               tx_send,
    output logic [7:0]         tx_data,
    input  logic               tx_ready,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               msg_done
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

`ifdef UART_ARB_PREFIX_EN
    typedef enum logic [2:0] {IDLE, LOAD, SEND, BUSY, HOLD, PREFIX} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, SEND, BUSY, HOLD} state_t;
`endif

    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    gidx_q, gidx_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             last_q, last_d;
`ifdef UART_ARB_PREFIX_EN
    logic             pfx_q, pfx_d;
`else
    logic             unused_prefix_base;
    assign unused_prefix_base = ^PREFIX_BASE;
`endif

    logic [7:0]    req_bytes [N_REQ];
    logic          found;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] idx_v;
    logic          accept;
    logic          rel;
    logic          done_pulse;

    for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
        assign req_bytes[i] = req_data[i*8 +: 8];
    end

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        idx_v   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx_v = PW'((int'(ptr_q) + i) % N_REQ);
            if (!found && req_valid[idx_v]) begin
                found   = 1'b1;
                win_idx = idx_v;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gidx_d     = gidx_q;
        grant_d    = grant_q;
        burst_d    = burst_q;
        tx_data_d  = tx_data_q;
        last_d     = last_q;
        accept     = 1'b0;
        rel        = 1'b0;
        done_pulse = 1'b0;
`ifdef UART_ARB_PREFIX_EN
        pfx_d      = pfx_q;
`endif

        case (state_q)
            IDLE: begin
                if (found) begin
                    gidx_d  = win_idx;
                    grant_d = N_REQ'(1) << win_idx;
`ifdef UART_ARB_PREFIX_EN
                    state_d = PREFIX;
`else
                    state_d = LOAD;
`endif
                end
            end
            LOAD: begin
                if (req_valid[gidx_q]) begin
                    accept    = 1'b1;
                    tx_data_d = req_bytes[gidx_q];
                    last_d    = req_last[gidx_q];
                    if (MAX_BURST != 0) begin
                        burst_d = burst_q + 1'b1;
                    end
                    state_d   = SEND;
                end else begin
                    state_d = HOLD;
                end
            end
`ifdef UART_ARB_PREFIX_EN
            PREFIX: begin
                tx_data_d = PREFIX_BASE + 8'(gidx_q);
                pfx_d     = 1'b1;
                state_d   = SEND;
            end
`endif
            SEND: begin
                if (!tx_ready) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Entered only after tx_ready was seen low, so ready high here is the rising edge.
                if (tx_ready) begin
`ifdef UART_ARB_PREFIX_EN
                    if (pfx_q) begin
                        pfx_d   = 1'b0;
                        state_d = LOAD;
                    end else
`endif
                    if (last_q) begin
                        done_pulse = 1'b1;
                        rel        = 1'b1;
                    end else if (MAX_BURST != 0 && burst_q == BW'(MAX_BURST)) begin
                        rel = 1'b1;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (req_valid[gidx_q]) begin
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rel) begin
            ptr_d   = PW'((int'(gidx_q) + 1) % N_REQ);
            burst_d = '0;
            grant_d = '0;
            state_d = IDLE;
        end

        // Flush overrides everything; an accepted byte is dropped and the pointer is kept.
        if (clear) begin
            state_d    = IDLE;
            ptr_d      = ptr_q;
            grant_d    = '0;
            burst_d    = '0;
            tx_data_d  = tx_data_q;
            last_d     = last_q;
            accept     = 1'b0;
            done_pulse = 1'b0;
`ifdef UART_ARB_PREFIX_EN
            pfx_d      = 1'b0;
`endif
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gidx_q    <= '0;
            grant_q   <= '0;
            burst_q   <= '0;
            tx_data_q <= 8'h00;
            last_q    <= 1'b0;
`ifdef UART_ARB_PREFIX_EN
            pfx_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
            grant_q   <= grant_d;
            burst_q   <= burst_d;
            tx_data_q <= tx_data_d;
            last_q    <= last_d;
`ifdef UART_ARB_PREFIX_EN
            pfx_q     <= pfx_d;
`endif
        end
    end

    assign req_ready = accept ? grant_q : '0;
    assign tx_send   = (state_q == SEND);
    assign tx_data   = tx_data_q;
    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);
    assign msg_done  = done_pulse;

endmodule
